// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: one registered output stage backed by a 1-entry skid buffer.
// Optional CSR-uimm decode is enabled by defining IMM_GEN_ZICSR_EN.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_CSR  = 3'd6,
    FMT_RSVD = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t dec;
  entry_t out_q;
  entry_t skid_q;
  logic   out_valid_q;
  logic   skid_valid_q;
  logic   accept;
  logic   out_free;

  // NOTE: combinational decode uses blocking assignments with every field defaulted
  // first, so no path leaves a field unassigned and no latch is inferred.
  always_comb begin
    dec     = '0;
    dec.tag = in_tag;
    case (in_instr[6:0])
      7'b0000011, 7'b1100111, 7'b0010011, 7'b0011011: begin
        dec.fmt = FMT_I;
        dec.imm = XLEN'($signed(in_instr[31:20]));
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        dec.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        dec.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        dec.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        dec.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
      end
`ifdef IMM_GEN_ZICSR_EN
      7'b1110011: begin
        // Only the immediate CSR forms (csrrwi/csrrsi/csrrci) carry a uimm.
        if (in_instr[14:12] inside {3'b101, 3'b110, 3'b111}) begin
          dec.fmt = FMT_CSR;
          dec.imm = XLEN'(in_instr[19:15]);
        end
      end
`endif
      default: begin
        dec.fmt = FMT_NONE;
        dec.imm = '0;
      end
    endcase
  end

  // in_ready is purely the complement of a flop, so it never depends on out_ready.
  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready && !flush;
  assign out_free = !out_valid_q || out_ready;

  // NOTE: the data registers are reset (not just the valid bits) because the
  // output payload must read as zero whenever no entry is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        // Skid full implies in_ready=0, so no new entry can arrive this cycle.
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
        skid_q       <= '0;
      end else if (accept) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_q       <= '0;
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_imm   = out_q.imm;
  assign out_fmt   = out_q.fmt;
  assign out_tag   = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream,
// checked against an arithmetic reference decode model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic [7:0]  out_tag;
  logic        in_ready64, out_valid64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic [7:0]  out_tag64;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [7:0]  tag;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_tag(out_tag)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_tag(out_tag64)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference decode: immediates built by shifting/scaling the sign-extended word.
  function automatic exp_t model(input logic [31:0] i, input logic [7:0] tag);
    exp_t   e;
    longint s;
    s     = longint'($signed(i));
    e.imm = '0;
    e.fmt = 3'd0;
    e.tag = tag;
    case (i[6:0])
      7'b0000011, 7'b1100111, 7'b0010011, 7'b0011011: begin
        e.fmt = 3'd1;
        e.imm = s >>> 20;
      end
      7'b0100011: begin
        e.fmt = 3'd2;
        e.imm = (s >>> 25) * 32 + longint'(i[11:7]);
      end
      7'b1100011: begin
        e.fmt = 3'd3;
        e.imm = (s >>> 31) * 4096 + longint'(i[7]) * 2048
              + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
      end
      7'b0110111, 7'b0010111: begin
        e.fmt = 3'd4;
        e.imm = (s >>> 12) * 4096;
      end
      7'b1101111: begin
        e.fmt = 3'd5;
        e.imm = (s >>> 31) * 1048576 + longint'(i[19:12]) * 4096
              + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
      end
`ifdef IMM_GEN_ZICSR_EN
      7'b1110011: begin
        if (i[14:12] >= 3'd5) begin
          e.fmt = 3'd6;
          e.imm = longint'(i[19:15]);
        end
      end
`endif
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: compares the presented entry with the scoreboard head, then
  // applies the handshake that the next rising edge will perform.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_imm64", out_imm64, 0);
      check("rst_out_fmt", out_fmt, 0);
    end else begin
      check("out_valid", out_valid, q.size() > 0);
      check("in_ready", in_ready, q.size() < 2);
      check("out_valid64", out_valid64, q.size() > 0);
      check("in_ready64", in_ready64, q.size() < 2);
      if (out_valid && q.size() > 0) begin
        check("sb_imm32", out_imm, q[0].imm[31:0]);
        check("sb_imm64", out_imm64, q[0].imm);
        check("sb_fmt", out_fmt, q[0].fmt);
        check("sb_fmt64", out_fmt64, q[0].fmt);
        check("sb_tag", out_tag, q[0].tag);
        check("sb_tag64", out_tag64, q[0].tag);
      end else if (!out_valid) begin
        check("idle_imm32", out_imm, 0);
        check("idle_fmt", out_fmt, 0);
        check("idle_imm64", out_imm64, 0);
      end
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
        if (in_valid && in_ready) q.push_back(model(in_instr, in_tag));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic push(input logic [31:0] instr, input logic [7:0] tag);
    bit ok;
    in_valid = 1'b1;
    in_instr = instr;
    in_tag   = tag;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    n_tests++;
    n_fail++;
    $display("FAIL push_timeout: instr %h not accepted within 40 cycles", instr);
  endtask

  task automatic push_check(input string name, input logic [31:0] instr, input logic [7:0] tag,
                            input logic [63:0] exp_imm, input logic [2:0] exp_fmt);
    push(instr, tag);
    @(negedge clk);
    check({name, "_valid"}, out_valid, 1);
    check({name, "_imm32"}, out_imm, exp_imm[31:0]);
    check({name, "_imm64"}, out_imm64, exp_imm);
    check({name, "_fmt"}, out_fmt, exp_fmt);
    check({name, "_tag"}, out_tag, tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] held_imm;
    logic [7:0]  held_tag;
    logic [6:0]  ops [11];
    ops = '{7'b0000011, 7'b1100111, 7'b0010011, 7'b0011011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b0110011};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;
    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_imm", out_imm, 0);
    check("reset_out_fmt", out_fmt, 0);
    check("reset_out_tag", out_tag, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    out_ready = 1'b1;
    push_check("addi", 32'hFFF00093, 8'h11, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
    push_check("sw",   32'h00112623, 8'h21, 64'h0000_0000_0000_000C, 3'd2);
    push_check("beq",  32'hFE000EE3, 8'h22, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3);
    push_check("jal",  32'h0080006F, 8'h23, 64'h0000_0000_0000_0008, 3'd5);
    push_check("lui",  32'h800000B7, 8'h31, 64'hFFFF_FFFF_8000_0000, 3'd4);
    push_check("add",  32'h00000033, 8'h32, 64'h0, 3'd0);
`ifdef IMM_GEN_ZICSR_EN
    push_check("csrwi", 32'h3401D073, 8'h41, 64'h3, 3'd6);
`else
    push_check("csrwi", 32'h3401D073, 8'h41, 64'h0, 3'd0);
`endif

    // Backpressure: two accepts fill output+skid, the third waits.
    out_ready = 1'b0;
    push(32'h00100093, 8'h01);
    push(32'h00200093, 8'h02);
    in_valid = 1'b1; in_instr = 32'h00300093; in_tag = 8'h03;
    @(negedge clk);
    check("bp_in_ready", in_ready, 0);
    held_imm = out_imm;
    held_tag = out_tag;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_imm", out_imm, held_imm);
      check("bp_hold_tag", out_tag, held_tag);
      check("bp_in_ready_low", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_order1", out_tag, 8'h01);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_order2", out_tag, 8'h02);
    check("bp_in_ready_back", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_order3_valid", out_valid, 1);
    check("bp_order3", out_tag, 8'h03);
    @(posedge clk); #1;

    // Flush with output and skid full, plus a concurrent input.
    out_ready = 1'b0;
    push(32'h00500093, 8'h05);
    push(32'h00600093, 8'h06);
    in_valid = 1'b1; in_instr = 32'h00700093; in_tag = 8'h07; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_full_valid", out_valid, 0);
    check("flush_full_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("flush_full_empty", out_valid, 0);
    end
    @(posedge clk); #1;

    // Flush while in_ready=1: the presented input must be dropped.
    out_ready = 1'b0;
    push(32'h00800093, 8'h08);
    in_valid = 1'b1; in_instr = 32'h00900093; in_tag = 8'h09; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("flush_drop_empty", out_valid, 0);
      check("flush_drop_ready", in_ready, 1);
    end
    @(posedge clk); #1;

    // Randomized traffic with an asynchronous reset mid-stream.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      in_tag    = 8'($urandom());
      in_instr  = {25'($urandom() >> 7), ops[$urandom_range(0, 10)]};
      if ($urandom_range(0, 19) == 0) in_instr[6:0] = 7'($urandom());
      if (i == 1500) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_ready", in_ready, 1);
        check("async_rst_imm64", out_imm64, 0);
        check("async_rst_fmt", out_fmt, 0);
        check("async_rst_tag", out_tag, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      @(posedge clk); #1;
    end

    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("drain_empty", out_valid, 0);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the decode stage of the pipelined core.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake.
- Outputs the XLEN-wide immediate, a format code and a sideband tag, one registered stage later.
- A 1-entry skid buffer keeps in_ready fully registered; flush discards all held entries.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. All immediates are sign-extended to XLEN.
- TAG_W, 8, width of the sideband tag carried alongside the instruction (PC index, ROB id, ...).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; drop all held entries.
- in_valid  in  1  input instruction valid.
- in_ready  out  1  block can accept; driven from a register.
- in_instr  in  32  instruction word.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  immediate.
- out_fmt  out  3  0=none, 1=I, 2=S, 3=B, 4=U, 5=J, 6=CSR-uimm, 7 reserved.
- out_tag  out  TAG_W  tag of the output entry.

Behaviour:
- Reset (async assert, sync release): out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_tag=0, skid empty.
- Decode by opcode in_instr[6:0], with i = in_instr:
  - 0000011, 1100111, 0010011, 0011011 (OP-IMM-32): I; imm = sext(i[31:20]).
  - 0100011: S; sext({i[31:25], i[11:7]}).
  - 1100011: B; sext({i[31], i[7], i[30:25], i[11:8], 0}).
  - 0110111, 0010111: U; sext({i[31:12], 12'b0}). With XLEN=64 the upper 32 bits are copies of i[31].
  - 1101111: J; sext({i[31], i[19:12], i[20], i[30:21], 0}).
  - Any other opcode: fmt=0, imm=0.
- Handshake:
  - A transfer occurs when valid&&ready on either side.
  - Latency is exactly 1 cycle: the instruction accepted at edge N appears on out_* after edge N.
- Storage: output register plus one skid register.
  - Accept while output empty, or output draining this cycle: the decoded entry goes to the output register.
  - Accept while output full and not draining: the entry goes to the skid register and in_ready deasserts next cycle.
  - Output drains while skid is full: the skid entry moves to the output register and in_ready reasserts next cycle.
  - No entry is lost, duplicated or reordered.
- out_* holds stable while out_valid=1 and out_ready=0.
- flush:
  - Next cycle out_valid=0, skid empty, in_ready=1.
  - An input presented in the flush cycle is discarded even if in_valid&&in_ready.
  - flush has priority over every other event.
- Reset mid-operation clears all state immediately, regardless of clk.
- out_imm and out_fmt are zeroed whenever out_valid=0.

Optional Feature:
- Macro: IMM_GEN_ZICSR_EN.
- Defined: opcode 1110011 with funct3 (i[14:12]) in {101,110,111} gives fmt=6 and imm = zero-extended i[19:15] (5-bit uimm). Other funct3 values give fmt=0.
- Undefined: opcode 1110011 always gives fmt=0, imm=0, and no CSR logic is generated.

Test Plan:
- XLEN=32, in_instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1; tag echoed.
- Back-to-back 0x00112623 (sw, 12), 0xFE000EE3 (beq, -4), 0x0080006F (jal, 8) -> three consecutive outputs:
  - imm 0x0000000C, fmt 2;
  - imm 0xFFFFFFFC, fmt 3;
  - imm 0x00000008, fmt 5.
- XLEN=64, in_instr=0x800000B7 (lui 0x80000) -> out_imm=0xFFFFFFFF80000000, out_fmt=4; 0x00000033 (add) -> fmt=0, imm=0.
- Hold out_ready=0 and push 3 instructions:
  - first two are accepted;
  - in_ready=0 from the cycle after the second accept;
  - out_* is stable;
  - releasing out_ready delivers 1, 2, 3 in order with no gaps.
- Output and skid both full, assert flush together with a new in_valid -> next cycle out_valid=0, in_ready=1; later out_ready=1 yields no entry. Deassert rst_n mid-stream -> outputs reset asynchronously.
- With IMM_GEN_ZICSR_EN, in_instr=0x3401D073 (csrwi mscratch,3) -> fmt=6, imm=3. Without the macro -> fmt=0, imm=0.
